dac_wave_sequencer: RTL

Upstream feeder for the DAC serializer in the multipath ultrasound transmitter. On each sample tick it reads a 64-entry 16-bit sine table for four channels, each at its own phase index. It presents the four words one at a time over a valid/ready handshake, then advances every phase index by a programmable step. The serializer consumes one word per handshake and shifts it out to the DAC.

---
 rtl/dac_wave_pkg.sv | 28 ++
 rtl/sine_rom64.sv | 14 +
 rtl/dac_wave_sequencer.sv | 74 +++++++
 3 files changed

// File: rtl/dac_wave_pkg.sv
// dac_wave_pkg: shared widths, FSM states and the 64-entry offset-binary sine table
package dac_wave_pkg;
    localparam int TABLE_AW    = 6;
    localparam int SAMPLE_W    = 16;
    localparam int TABLE_DEPTH = 1 << TABLE_AW;

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT, ADVANCE} state_t;

    // round(32767.5 + 32767.5*sin(2*pi*n/64))
    localparam logic [SAMPLE_W-1:0] SINE_TABLE [TABLE_DEPTH] = '{
        16'h8000, 16'h8C8B, 16'h98F8, 16'hA527,
        16'hB0FB, 16'hBC56, 16'hC71C, 16'hD133,
        16'hDA82, 16'hE2F1, 16'hEA6D, 16'hF0E2,
        16'hF641, 16'hFA7C, 16'hFD89, 16'hFF61,
        16'hFFFF, 16'hFF61, 16'hFD89, 16'hFA7C,
        16'hF641, 16'hF0E2, 16'hEA6D, 16'hE2F1,
        16'hDA82, 16'hD133, 16'hC71C, 16'hBC56,
        16'hB0FB, 16'hA527, 16'h98F8, 16'h8C8B,
        16'h8000, 16'h7374, 16'h6707, 16'h5AD8,
        16'h4F04, 16'h43A9, 16'h38E3, 16'h2ECC,
        16'h257D, 16'h1D0E, 16'h1592, 16'h0F1D,
        16'h09BE, 16'h0583, 16'h0276, 16'h009E,
        16'h0000, 16'h009E, 16'h0276, 16'h0583,
        16'h09BE, 16'h0F1D, 16'h1592, 16'h1D0E,
        16'h257D, 16'h2ECC, 16'h38E3, 16'h43A9,
        16'h4F04, 16'h5AD8, 16'h6707, 16'h7374
    };
endpackage

// File: rtl/sine_rom64.sv
// sine_rom64: registered single-cycle read of the package sine table, held between reads
module sine_rom64
    import dac_wave_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  logic [TABLE_AW-1:0] addr,
    output logic [SAMPLE_W-1:0] data
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) data <= '0;
        else if (rd_en) data <= SINE_TABLE[addr];
endmodule

// File: rtl/dac_wave_sequencer.sv
// dac_wave_sequencer: per-tick frame of one sine word per channel over valid/ready, then phase advance
module dac_wave_sequencer
    import dac_wave_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int PHASE_SPACING = 16
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [TABLE_AW-1:0] step,
    input  logic                sample_tick,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic [1:0]          sample_ch,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                frame_done,
    output logic                overrun,
    input  logic                clr_overrun
);
    state_t state, state_n;
    logic [TABLE_AW-1:0] idx [NUM_CH];
    logic [TABLE_AW-1:0] step_q;
    logic [1:0] ch_q;
    logic start, hs, last;

    assign start        = state == IDLE && sample_tick && en;
    assign sample_valid = state == PRESENT;
    assign frame_done   = state == ADVANCE;
    assign hs           = sample_valid && sample_ready;
    assign last         = ch_q == 2'(NUM_CH - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = PRESENT;
            PRESENT: state_n = !sample_ready ? PRESENT : last ? ADVANCE : LOAD;
            ADVANCE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            step_q    <= '0;
            ch_q      <= '0;
            sample_ch <= '0;
            overrun   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) idx[c] <= TABLE_AW'(c * PHASE_SPACING);
        end else begin
            if (start) begin
                step_q <= step;
                ch_q   <= '0;
            end else if (hs && !last) ch_q <= ch_q + 2'd1;
            if (state == LOAD) sample_ch <= ch_q;
            if (state == ADVANCE)
                for (int c = 0; c < NUM_CH; c++) idx[c] <= idx[c] + step_q;
            // a tick while busy is dropped; set beats clear
            overrun <= (sample_tick && en && state != IDLE) || (overrun && !clr_overrun);
        end

    sine_rom64 u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_en (state == LOAD),
        .addr  (idx[ch_q]),
        .data  (sample_data)
    );
endmodule
